// File: rtl/fp_io_pkg.sv
// Shared definitions for the board-I/O to FP-ALU operand path:
// sequencer states, ALU op codes and flag bit positions.
package fp_io_pkg;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    START   = 3'd3,
    WAIT    = 3'd4,
    SHOW    = 3'd5
  } state_e;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // ALU flag positions; the timeout bit sits just above them in flags_q
  localparam int FLAG_NV      = 0;
  localparam int FLAG_DZ      = 1;
  localparam int FLAG_OF      = 2;
  localparam int FLAG_UF      = 3;
  localparam int FLAG_NX      = 4;
  localparam int FLAG_TIMEOUT = 5;

endpackage

// File: rtl/operand_loader_if.sv
// Board-side and ALU-side signals of the operand loader, bundled with
// a slave view for the loader and a master view for its environment.
interface operand_loader_if #(
   parameter int DATA_W = 32,
   parameter int SW_W   = 16,
   parameter int OP_W   = 2,
   parameter int FLAG_W = 5
);
   localparam int N     = DATA_W / SW_W;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   logic              btnC;
   logic              cancel;
   logic [SW_W-1:0]   sw;
   logic              alu_done;
   logic [DATA_W-1:0] alu_result;
   logic [FLAG_W-1:0] alu_flags;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [OP_W-1:0]   op_code;
   logic              alu_start;
   logic [DATA_W-1:0] result_q;
   logic [FLAG_W:0]   flags_q;
   logic [2:0]        phase;
   logic [IDX_W-1:0]  chunk_idx;
   logic              busy;

   modport slave (
      input  btnC, cancel, sw, alu_done, alu_result, alu_flags,
      output op_a, op_b, op_code, alu_start, result_q, flags_q, phase, chunk_idx, busy
   );

   modport master (
      output btnC, cancel, sw, alu_done, alu_result, alu_flags,
      input  op_a, op_b, op_code, alu_start, result_q, flags_q, phase, chunk_idx, busy
   );
endinterface

// File: rtl/operand_loader_btn_edge.sv
// Two-flop synchronizer for an asynchronous button followed by a
// rising-edge one-shot: a held button yields a single-cycle press.
module btn_edge (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_press
);
   logic r_s1, r_s2, r_s3;

   // NOTE: non-blocking assignments make the three flops shift in lockstep; blocking would collapse the chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= i_btn;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign o_press = r_s2 & ~r_s3;
endmodule

// File: rtl/operand_loader.sv
// Operand sequencer: builds operands A and B from switch chunks, captures
// an op code, launches the ALU and latches its result or a timeout.
module operand_loader
   import fp_io_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int SW_W    = 16,
   parameter int OP_W    = 2,
   parameter int FLAG_W  = 5,
   parameter int TIMEOUT = 64
) (
   input logic              clk,
   input logic              reset,
   operand_loader_if.slave  bus
);
   localparam int N     = DATA_W / SW_W;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_e            r_state, w_state_nxt;
   logic [IDX_W-1:0]  r_idx, w_idx_nxt;
   logic [TMO_W-1:0]  r_tmo;
   logic [DATA_W-1:0] r_op_a, r_op_b, r_result;
   logic [OP_W-1:0]   r_op_code;
   logic [FLAG_W:0]   r_flags;
   logic              w_press, w_last_chunk, w_tmo_last;
   logic              w_wr_a, w_wr_b, w_wr_op, w_cap_done, w_cap_tmo;

   btn_edge u_btn_edge (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (bus.btnC),
      .o_press (w_press)
   );

   assign w_last_chunk = (r_idx == IDX_W'(N - 1));
   assign w_tmo_last   = (r_tmo == TMO_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= LOAD_A;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_wr_a      = 1'b0;
      w_wr_b      = 1'b0;
      w_wr_op     = 1'b0;
      w_cap_done  = 1'b0;
      w_cap_tmo   = 1'b0;
      if (bus.cancel && r_state != WAIT) begin
         w_state_nxt = LOAD_A;
         w_idx_nxt   = '0;
      end else begin
         case (r_state)
            LOAD_A, LOAD_B: begin
               if (w_press) begin
                  w_wr_a    = (r_state == LOAD_A);
                  w_wr_b    = (r_state == LOAD_B);
                  w_idx_nxt = w_last_chunk ? '0 : r_idx + 1'b1;
                  if (w_last_chunk) w_state_nxt = (r_state == LOAD_A) ? LOAD_B : LOAD_OP;
               end
            end
            LOAD_OP: begin
               if (w_press) begin
                  w_wr_op     = 1'b1;
                  w_state_nxt = START;
               end
            end
            START: w_state_nxt = WAIT;
            WAIT: begin
               // a result arriving on the expiry cycle still counts as a result
               if (bus.alu_done) begin
                  w_cap_done  = 1'b1;
                  w_state_nxt = SHOW;
               end else if (w_tmo_last) begin
                  w_cap_tmo   = 1'b1;
                  w_state_nxt = SHOW;
               end
            end
            SHOW: begin
               if (w_press) begin
                  w_state_nxt = LOAD_A;
                  w_idx_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = LOAD_A;
               w_idx_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op_a    <= '0;
         r_op_b    <= '0;
         r_op_code <= '0;
         r_result  <= '0;
         r_flags   <= '0;
         r_tmo     <= '0;
      end else begin
         if (w_wr_a) r_op_a[r_idx*SW_W +: SW_W] <= bus.sw;
         if (w_wr_b) r_op_b[r_idx*SW_W +: SW_W] <= bus.sw;
         if (w_wr_op) r_op_code <= bus.sw[OP_W-1:0];
         if (w_cap_done) begin
            r_result <= bus.alu_result;
            r_flags  <= {1'b0, bus.alu_flags};
         end else if (w_cap_tmo) begin
            r_flags  <= {1'b1, {FLAG_W{1'b0}}};
         end
         if (r_state == START)     r_tmo <= '0;
         else if (r_state == WAIT) r_tmo <= r_tmo + 1'b1;
      end
   end

   assign bus.op_a      = r_op_a;
   assign bus.op_b      = r_op_b;
   assign bus.op_code   = r_op_code;
   assign bus.result_q  = r_result;
   assign bus.flags_q   = r_flags;
   assign bus.phase     = r_state;
   assign bus.chunk_idx = r_idx;
   assign bus.alu_start = (r_state == START);
   assign bus.busy      = (r_state == START) || (r_state == WAIT);
endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: directed press sequences push the
// expected launch and result into queues; a monitor pops and compares.
module tb_operand_loader;
   import fp_io_pkg::*;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
   } launch_t;

   typedef struct {
      logic [31:0] r;
      logic [5:0]  f;
   } res_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   operand_loader_if #(.DATA_W(32), .SW_W(16), .OP_W(2), .FLAG_W(5)) u_if ();
   operand_loader_if #(.DATA_W(64), .SW_W(16), .OP_W(2), .FLAG_W(5)) u_if64 ();

   operand_loader #(.DATA_W(32), .SW_W(16), .OP_W(2), .FLAG_W(5), .TIMEOUT(64)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   operand_loader #(.DATA_W(64), .SW_W(16), .OP_W(2), .FLAG_W(5), .TIMEOUT(64)) u_dut64 (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if64.slave)
   );

   int n_checks = 0;
   int n_errors = 0;
   launch_t q_launch[$];
   res_t    q_result[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ALU model: replies alu_lat cycles after a start; can also emit a stray done
   logic        alu_en = 1'b0;
   int          alu_lat = 3;
   logic [31:0] alu_res = '0;
   logic [4:0]  alu_flg = '0;
   int          stray_req = 0;
   int          stray_done = 0;

   initial begin
      u_if.alu_done   = 1'b0;
      u_if.alu_result = '0;
      u_if.alu_flags  = '0;
      forever begin
         @(negedge clk);
         if (alu_en && u_if.alu_start) begin
            repeat (alu_lat) @(negedge clk);
            u_if.alu_result = alu_res;
            u_if.alu_flags  = alu_flg;
            u_if.alu_done   = 1'b1;
            @(negedge clk);
            u_if.alu_done   = 1'b0;
         end else if (stray_req != stray_done) begin
            stray_done      = stray_req;
            u_if.alu_result = alu_res;
            u_if.alu_flags  = alu_flg;
            u_if.alu_done   = 1'b1;
            @(negedge clk);
            u_if.alu_done   = 1'b0;
         end
      end
   end

   // Monitor: compares launches and displayed results, measures WAIT length
   logic [2:0] prev_phase = 3'd0;
   int wait_cnt = 0;
   int last_wait = 0;
   int n_starts = 0;

   always @(negedge clk) begin
      if (!reset) begin
         if (u_if.alu_start) begin
            n_starts++;
            if (q_launch.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL launch_unexpected: got start with op_a 0x%0h, required no start", u_if.op_a);
            end else begin
               launch_t e;
               e = q_launch.pop_front();
               check("launch_op_a", u_if.op_a, e.a);
               check("launch_op_b", u_if.op_b, e.b);
               check("launch_op_code", u_if.op_code, e.op);
            end
         end
         if (prev_phase == 3'd4 && u_if.phase == 3'd5) begin
            if (q_result.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL show_unexpected: got SHOW with result 0x%0h, required none", u_if.result_q);
            end else begin
               res_t e;
               e = q_result.pop_front();
               check("show_result_q", u_if.result_q, e.r);
               check("show_flags_q", u_if.flags_q, e.f);
            end
         end
         if (u_if.phase == 3'd4) wait_cnt++;
         else begin
            if (prev_phase == 3'd4) last_wait = wait_cnt;
            wait_cnt = 0;
         end
      end
      prev_phase = u_if.phase;
   end

   task automatic press(input bit wide, input logic [15:0] v);
      @(negedge clk);
      if (wide) begin u_if64.sw = v; u_if64.btnC = 1'b1; end
      else      begin u_if.sw   = v; u_if.btnC   = 1'b1; end
      repeat (4) @(negedge clk);
      if (wide) u_if64.btnC = 1'b0;
      else      u_if.btnC   = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_phase(input logic [2:0] target, input int max_cycles, input string name);
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (u_if.phase == target) break;
      end
      check(name, u_if.phase, target);
   endtask

   initial begin
      reset = 1'b1;
      u_if.btnC = 1'b0;   u_if.cancel = 1'b0;   u_if.sw = '0;
      u_if64.btnC = 1'b0; u_if64.cancel = 1'b0; u_if64.sw = '0;
      u_if64.alu_done = 1'b0; u_if64.alu_result = '0; u_if64.alu_flags = '0;

      repeat (2) @(negedge clk);
      check("rst_op_a", u_if.op_a, 0);
      check("rst_op_b", u_if.op_b, 0);
      check("rst_phase", u_if.phase, 0);
      check("rst_alu_start", u_if.alu_start, 0);
      check("rst_flags_q", u_if.flags_q, 0);
      check("rst_busy_idx", {u_if.busy, u_if.chunk_idx}, 0);
      reset = 1'b0;

      // Add: 3.5 + 2.25 = 5.5
      alu_en = 1'b1; alu_lat = 3; alu_res = 32'h40B0_0000; alu_flg = 5'h00;
      q_launch.push_back('{a: 32'h4060_0000, b: 32'h4010_0000, op: OP_ADD});
      q_result.push_back('{r: 32'h40B0_0000, f: 6'h00});
      press(0, 16'h0000);
      press(0, 16'h4060);
      check("add_a_done_phase", u_if.phase, 1);
      check("add_a_done_idx", u_if.chunk_idx, 0);
      check("add_op_a", u_if.op_a, 32'h4060_0000);
      press(0, 16'h0000);
      press(0, 16'h4010);
      check("add_b_done_phase", u_if.phase, 2);
      check("add_op_b", u_if.op_b, 32'h4010_0000);

      // 5th press with cycle-exact launch timing
      @(negedge clk);
      u_if.sw = 16'h0000; u_if.btnC = 1'b1;
      @(posedge clk); @(negedge clk);
      check("start_k0", u_if.alu_start, 0);
      @(posedge clk); @(negedge clk);
      check("start_k1", u_if.alu_start, 0);
      @(posedge clk); @(negedge clk);
      check("start_k2", {u_if.alu_start, u_if.busy}, 2'b11);
      @(negedge clk);
      check("start_k3", {u_if.alu_start, u_if.phase}, {1'b0, 3'd4});
      repeat (2) @(negedge clk);
      u_if.btnC = 1'b0;
      wait_phase(3'd5, 200, "add_show_phase");
      check("add_start_count", n_starts, 1);

      // Leave SHOW; operands retained
      press(0, 16'h0000);
      check("show_exit_phase", u_if.phase, 0);
      check("show_exit_op_a", u_if.op_a, 32'h4060_0000);

      // Held button: one chunk only
      @(negedge clk);
      u_if.sw = 16'h1234; u_if.btnC = 1'b1;
      repeat (20) @(negedge clk);
      check("hold_idx", u_if.chunk_idx, 1);
      check("hold_op_a", u_if.op_a, 32'h4060_1234);
      u_if.btnC = 1'b0;
      repeat (4) @(negedge clk);

      // Cancel after first B chunk
      press(0, 16'hABCD);
      press(0, 16'h5555);
      check("pre_cancel_state", {u_if.phase, 1'b0, u_if.chunk_idx}, {3'd1, 1'b0, 1'b1});
      u_if.cancel = 1'b1;
      @(negedge clk);
      u_if.cancel = 1'b0;
      check("cancel_state", {u_if.phase, 1'b0, u_if.chunk_idx}, 0);
      check("cancel_op_a", u_if.op_a, 32'hABCD_1234);
      check("cancel_op_b", u_if.op_b, 32'h4010_5555);

      // Timeout with cancel in WAIT ignored; result_q keeps the add result
      alu_en = 1'b0;
      q_launch.push_back('{a: 32'h3F80_0001, b: 32'h4000_0002, op: OP_DIV});
      q_result.push_back('{r: 32'h40B0_0000, f: 6'b10_0000});
      press(0, 16'h0001);
      press(0, 16'h3F80);
      press(0, 16'h0002);
      press(0, 16'h4000);
      press(0, 16'h0003);
      check("tmo_in_wait", u_if.phase, 4);
      u_if.cancel = 1'b1;
      @(negedge clk);
      u_if.cancel = 1'b0;
      check("wait_cancel_ignored", {u_if.phase, u_if.busy}, {3'd4, 1'b1});
      wait_phase(3'd5, 200, "tmo_show_phase");
      @(negedge clk);
      check("tmo_wait_len", last_wait, 64);

      // alu_done on the very cycle the timeout would expire
      alu_en = 1'b1; alu_lat = 64; alu_res = 32'h40C0_0000; alu_flg = 5'b00101;
      q_launch.push_back('{a: 32'h4000_0000, b: 32'h4040_0000, op: OP_MUL});
      q_result.push_back('{r: 32'h40C0_0000, f: 6'b00_0101});
      press(0, 16'h0000);
      press(0, 16'h0000);
      press(0, 16'h4000);
      press(0, 16'h0000);
      press(0, 16'h4040);
      press(0, 16'h0002);
      wait_phase(3'd5, 200, "tie_show_phase");
      @(negedge clk);
      check("tie_wait_len", last_wait, 64);

      // Stray alu_done in SHOW is ignored
      alu_en = 1'b0; alu_res = 32'hDEAD_BEEF; alu_flg = 5'h1F;
      stray_req++;
      repeat (4) @(negedge clk);
      check("stray_result_q", u_if.result_q, 32'h40C0_0000);
      check("stray_flags_q", u_if.flags_q, 6'h05);
      check("total_starts", n_starts, 3);
      check("launch_q_empty", q_launch.size(), 0);
      check("result_q_empty", q_result.size(), 0);

      // 64-bit variant: four chunks per operand, index wraps 3 -> 0
      press(1, 16'h1111);
      press(1, 16'h2222);
      press(1, 16'h3333);
      check("w64_idx3", {u_if64.phase, 1'b0, u_if64.chunk_idx}, {3'd0, 1'b0, 2'd3});
      press(1, 16'h4444);
      check("w64_wrap", {u_if64.phase, 1'b0, u_if64.chunk_idx}, {3'd1, 1'b0, 2'd0});
      check("w64_op_a", u_if64.op_a, 64'h4444_3333_2222_1111);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, required finish before 2 ms");
      $fatal(1, "bench time limit");
   end
endmodule
